aes_encrypt_core: RTL and testbench

//  Iterative AES-128 encryption engine: the forward-direction counterpart of the inverse-round decrypt path.

---
 rtl/aes_encrypt_core.sv | 126 ++++++++++++
 tb/tb_aes_encrypt_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryptor, one round per clock, round keys expanded on the fly.
// Define AES_ENC_LASTKEY_OUT_EN to add the last_key port (final round key, valid in DONE).
module aes_encrypt_core #(
   parameter int NR = 10
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] plaintext,
   input  logic [0:127] cipher_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] ciphertext
`ifdef AES_ENC_LASTKEY_OUT_EN
   ,
   output logic [0:127] last_key
`endif
);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   state_e       state_q, state_d;
   logic [0:127] st_q, st_d, rk_q, rk_d, rk_nxt, sb_sr;
   logic [3:0]   rnd_q, rnd_d;
   logic [7:0]   rcon_q, rcon_d;
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction
   // Byte r of column c lives at index r+4c; row r rotates left by r columns.
   function automatic logic [0:127] sub_shift(input logic [0:127] s);
      logic [0:127] r;
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 4; i++)
            r[8*(i+4*c) +: 8] = sbox(s[8*(i+4*((c+i)%4)) +: 8]);
      return r;
   endfunction
   function automatic logic [0:127] mix_cols(input logic [0:127] s);
      logic [0:127] r;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         r[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction
   function automatic logic [0:127] key_exp(input logic [0:127] k, input logic [7:0] rc);
      logic [0:127] r;
      logic [31:0]  w3, t;
      w3 = k[96 +: 32];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      r[0 +: 32]  = k[0 +: 32] ^ t;
      r[32 +: 32] = k[32 +: 32] ^ r[0 +: 32];
      r[64 +: 32] = k[64 +: 32] ^ r[32 +: 32];
      r[96 +: 32] = k[96 +: 32] ^ r[64 +: 32];
      return r;
   endfunction
   assign rk_nxt = key_exp(rk_q, rcon_q);
   assign sb_sr  = sub_shift(st_q);
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         st_q    <= '0;
         rk_q    <= '0;
         rnd_q   <= '0;
         rcon_q  <= 8'h01;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         rnd_q   <= rnd_d;
         rcon_q  <= rcon_d;
      end
   end
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      rk_d    = rk_q;
      rnd_d   = rnd_q;
      rcon_d  = rcon_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            st_d    = plaintext ^ cipher_key;
            rk_d    = cipher_key;
            rnd_d   = 4'd1;
            rcon_d  = 8'h01;
         end
         RUN: begin
            rk_d = rk_nxt;
            if (rnd_q == 4'(NR)) begin
               st_d    = sb_sr ^ rk_nxt;
               state_d = DONE;
            end else begin
               st_d   = mix_cols(sb_sr) ^ rk_nxt;
               rnd_d  = rnd_q + 4'd1;
               rcon_d = xtime(rcon_q);
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign in_ready   = state_q == IDLE;
   assign out_valid  = state_q == DONE;
   assign ciphertext = out_valid ? st_q : '0;
`ifdef AES_ENC_LASTKEY_OUT_EN
   assign last_key   = out_valid ? rk_q : '0;
`endif
endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: FIPS-197 vectors, backpressure, mid-block reset and back-to-back traffic.
module tb_aes_encrypt_core;
   localparam int NR = 10;
   localparam logic [0:127] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:127] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   logic         Clk, Reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [0:127] plaintext, cipher_key, ciphertext, exp_in, exp_pop;
`ifdef AES_ENC_LASTKEY_OUT_EN
   localparam logic [0:127] B_LK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   logic [0:127] last_key;
`endif
   logic [0:127] sb_q[$];
   int           acc_q[$];
   int           cyc = 0, n_cmp = 0, n_err = 0, n_pop = 0;

   aes_encrypt_core #(.NR(NR)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .cipher_key(cipher_key), .out_valid(out_valid),
      .out_ready(out_ready), .ciphertext(ciphertext)
`ifdef AES_ENC_LASTKEY_OUT_EN
      , .last_key(last_key)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Scoreboard: push expected ct on an accept handshake, pop on an output handshake.
   always @(negedge Clk) begin
      if (Reset_n && in_valid && in_ready) begin
         sb_q.push_back(exp_in);
         acc_q.push_back(cyc);
      end
      if (Reset_n && out_valid && out_ready) begin
         n_pop++;
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: unexpected ciphertext %h", ciphertext);
         end else begin
            exp_pop = sb_q.pop_front();
            if (ciphertext !== exp_pop) begin
               n_err++;
               $display("FAIL scoreboard: ciphertext %h expected %h", ciphertext, exp_pop);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      plaintext = '0;
      cipher_key = '0;
      exp_in = '0;
      tick();
      tick();
      n_cmp += 3;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (ciphertext !== '0) begin n_err++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
`ifdef AES_ENC_LASTKEY_OUT_EN
      n_cmp++;
      if (last_key !== '0) begin n_err++; $display("FAIL reset_last_key: got %h want 0", last_key); end
`endif
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_app_b();
      int n;
      plaintext = B_PT;
      cipher_key = B_KEY;
      exp_in = B_CT;
      out_ready = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(n);
      n_cmp += 2;
      if (n !== NR) begin n_err++; $display("FAIL app_b_latency: got %0d cycles want %0d", n, NR); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL app_b_in_ready_done: got %b want 0", in_ready); end
`ifdef AES_ENC_LASTKEY_OUT_EN
      n_cmp++;
      if (last_key !== B_LK) begin n_err++; $display("FAIL app_b_last_key: got %h want %h", last_key, B_LK); end
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp += 2;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL app_b_release: out_valid %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL app_b_idle: in_ready %b want 1", in_ready); end
   endtask

   task automatic test_app_c();
      int n;
      plaintext = C_PT;
      cipher_key = C_KEY;
      exp_in = C_CT;
      out_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(n);
      n_cmp++;
      if (n !== NR) begin n_err++; $display("FAIL app_c_latency: got %0d cycles want %0d", n, NR); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL app_c_done_one_cycle: out_valid %b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      plaintext = B_PT;
      cipher_key = B_KEY;
      exp_in = B_CT;
      out_ready = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      plaintext = C_PT;
      cipher_key = C_KEY;
      exp_in = C_CT;
      wait_out(n);
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         tick();
         n_cmp++;
         if (ciphertext !== B_CT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_hold[%0d]: ct %h rdy %b vld %b want %h 0 1", i, ciphertext, in_ready, out_valid, B_CT);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL backpressure_release: rdy %b vld %b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_mid_reset();
      int n, seen;
      plaintext = B_PT;
      cipher_key = B_KEY;
      exp_in = B_CT;
      out_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      sb_q.delete();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_state: rdy %b vld %b want 1 0", in_ready, out_valid);
      end
      seen = 0;
      repeat (12) begin
         tick();
         if (out_valid) seen++;
      end
      n_cmp++;
      if (seen != 0) begin n_err++; $display("FAIL mid_reset_partial: out_valid seen %0d cycles want 0", seen); end
      plaintext = C_PT;
      cipher_key = C_KEY;
      exp_in = C_CT;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(n);
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (n !== NR) begin n_err++; $display("FAIL mid_reset_fresh_latency: got %0d want %0d", n, NR); end
   endtask

   task automatic test_back_to_back();
      int base, n;
      acc_q.delete();
      base = n_pop;
      plaintext = B_PT;
      cipher_key = B_KEY;
      exp_in = B_CT;
      out_ready = 1'b1;
      in_valid = 1'b1;
      n = 0;
      while (n_pop < base + 2 && n < 80) begin
         tick();
         n++;
         if (acc_q.size() == 1) begin
            plaintext = C_PT;
            cipher_key = C_KEY;
            exp_in = C_CT;
         end
         if (acc_q.size() >= 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_cmp += 2;
      if (n_pop - base !== 2) begin n_err++; $display("FAIL b2b_outputs: got %0d want 2", n_pop - base); end
      if (acc_q.size() < 2 || acc_q[1] - acc_q[0] !== NR + 2) begin
         n_err++;
         $display("FAIL b2b_spacing: accepts %0d spacing %0d want %0d", acc_q.size(),
                  acc_q.size() < 2 ? -1 : acc_q[1] - acc_q[0], NR + 2);
      end
   endtask

   initial begin
      test_reset();
      test_app_b();
      test_app_c();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      tick();
      n_cmp++;
      if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d results outstanding want 0", sb_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
